writeback_unit: RTL
===================

# writeback_unit

Writeback stage between the execute/load units and the core register file. Accepts results from the ALU and the load unit over valid/ready handshakes, aligns and sign-extends load data, and buffers results in a small in-order FIFO. Drains at most one entry per cycle onto the register file write port (rd, data, done strobe). Publishes a pending-write mask for hazard detection.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- iCLK  in  1  clock; all state updates on rising edge.
- iRST_N  in  1  synchronous active-low reset.
- iALU_VALID  in  1  ALU result valid.
- oALU_READY  out  1  ALU result can be accepted.
- iALU_RD  in  5  ALU destination register.
- iALU_OUT  in  32  ALU result.
- iLD_VALID  in  1  load result valid.
- oLD_READY  out  1  load result can be accepted.
- iLD_RD  in  5  load destination register.
- iLD_DATA  in  32  raw aligned memory word.
- iLD_FUNCT3  in  3  load type (RV32I funct3).
- iLD_ADDR_LO  in  2  byte address bits [1:0].
- iSTALL  in  1  hold writeback; no FIFO pop while high.
- oDONE  out  1  register file write strobe.
- oRD  out  5  register file write index.
- oWB_DATA  out  32  register file write data.
- oBUSY_MASK  out  32  bit r set when any FIFO entry targets xr; bit 0 always 0.
- oCOUNT  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO stores {rd[4:0], data[31:0]}. Read and write pointers wrap modulo DEPTH. The count register is the sole full/empty source.
- Handshakes are ready-registered: ready depends only on the count, never on valid.
  - oLD_READY = (count <= DEPTH-1).
  - oALU_READY = (count <= DEPTH-2), reserving a slot for a same-cycle load.
- A transfer occurs when valid && ready at the rising edge. When valid is high and ready is low, the source holds its data. There is no drop.
- Simultaneous accept: the load is enqueued first, then the ALU result (two pushes in one edge).
- Accepted entries with rd=0 are discarded and consume no slot.
- Load extraction, with byte index b = iLD_ADDR_LO:
  - 000 LB: sign-extend byte b.
  - 001 LH: sign-extend halfword iLD_ADDR_LO[1].
  - 010 LW: whole word.
  - 100 LBU: zero-extend byte b.
  - 101 LHU: zero-extend halfword iLD_ADDR_LO[1].
  - Other funct3 values: whole word.
  - iLD_ADDR_LO[0] is ignored for halfword loads (no misalign trap).
- Drain path:
  - oDONE = !empty && !iSTALL.
  - oRD and oWB_DATA show the FIFO head whenever the FIFO is non-empty, and 0 when empty.
  - The pop happens at the edge where oDONE=1.
- Push and pop in the same edge: count changes by pushes minus pop. A full FIFO may pop and accept a load in the same edge only if the count-based ready allowed it; ready is not recomputed within the cycle.
- oBUSY_MASK is the OR of one-hot(rd) over all valid entries. It updates with the registered FIFO state.
- Reset (iRST_N=0 at an edge): pointers and count go to 0 and all entries are invalidated. Any in-flight entries are lost.
- Reset outputs: oDONE=0, oRD=0, oWB_DATA=0, oBUSY_MASK=0, oCOUNT=0, oLD_READY=1, oALU_READY=1.

## Timing
- Latency: a result accepted at edge N appears on oDONE/oRD/oWB_DATA during cycle N+1 if the FIFO was empty and iSTALL=0. The register file writes it at edge N+1.
- Throughput: one writeback per cycle. Burst input of 2 per cycle is absorbed up to DEPTH.
- Ordering: strictly FIFO. Load before ALU on same-cycle ties.
- iSTALL is sampled combinationally into oDONE. Stall for K cycles keeps the head stable for K cycles.
- No combinational path from iALU_VALID/iLD_VALID to any output.

## Test plan
- Reset, then single ALU push rd=5, data=0x0000_1234 -> next cycle oDONE=1, oRD=5, oWB_DATA=0x0000_1234; following cycle oDONE=0, oBUSY_MASK=0.
- LB from word 0x80FF_7F01 at ADDR_LO=1 -> 0x0000_007F; at ADDR_LO=2 -> 0xFFFF_FFFF. LHU at ADDR_LO=2 -> 0x0000_80FF. LH at ADDR_LO=2 -> 0xFFFF_80FF.
- Same-cycle load (rd=3, LW 0xAAAA_AAAA) and ALU (rd=4, 0x5555_5555) -> two consecutive writebacks: rd=3 then rd=4. oBUSY_MASK=0x18 in the cycle between.
- iSTALL=1 with continuous pushes -> count reaches DEPTH-1, where oALU_READY=0 and oLD_READY=1. At DEPTH, both readies are 0 and sources hold. Release the stall -> DEPTH writebacks in order, no loss or duplication.
- Push with rd=0 (data 0xDEAD_BEEF) -> no oDONE, count unchanged, oBUSY_MASK bit 0 stays 0.
- Fill 3 entries under stall, assert iRST_N=0 for one edge -> count=0, oDONE=0, outputs zero, both readies 1. The old entries never appear after the stall is released.

Source files
------------

// File: rtl/writeback_unit_if.sv
// Writeback stage bus: ALU result channel, load result channel,
// stall input and the register file write port with hazard status.
interface writeback_unit_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // ALU result channel
  logic          iALU_VALID;
  logic          oALU_READY;
  logic [4:0]    iALU_RD;
  logic [31:0]   iALU_OUT;

  // Load result channel
  logic          iLD_VALID;
  logic          oLD_READY;
  logic [4:0]    iLD_RD;
  logic [31:0]   iLD_DATA;
  logic [2:0]    iLD_FUNCT3;
  logic [1:0]    iLD_ADDR_LO;

  // Drain control and register file write port
  logic          iSTALL;
  logic          oDONE;
  logic [4:0]    oRD;
  logic [31:0]   oWB_DATA;
  logic [31:0]   oBUSY_MASK;
  logic [CW-1:0] oCOUNT;

  // Writeback unit side
  modport slave (
    input  iALU_VALID, iALU_RD, iALU_OUT,
    input  iLD_VALID, iLD_RD, iLD_DATA, iLD_FUNCT3, iLD_ADDR_LO,
    input  iSTALL,
    output oALU_READY, oLD_READY,
    output oDONE, oRD, oWB_DATA, oBUSY_MASK, oCOUNT
  );

  // Execute/load/hazard side
  modport master (
    output iALU_VALID, iALU_RD, iALU_OUT,
    output iLD_VALID, iLD_RD, iLD_DATA, iLD_FUNCT3, iLD_ADDR_LO,
    output iSTALL,
    input  oALU_READY, oLD_READY,
    input  oDONE, oRD, oWB_DATA, oBUSY_MASK, oCOUNT
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: accepts ALU and load results, aligns/extends load data,
// queues results in an in-order FIFO and drains one per cycle to the
// register file. Publishes a pending-write mask for hazard detection.
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input logic             iCLK,
  input logic             iRST_N,
  writeback_unit_if.slave wb
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // Entry storage; validity of a slot is derived from pointers and count
  logic [4:0]    rdMem   [DEPTH];
  logic [31:0]   dataMem [DEPTH];

  logic [AW-1:0] rdPtrReg, rdPtrNext;
  logic [AW-1:0] wrPtrReg, wrPtrNext;
  logic [CW-1:0] countReg, countNext;
  logic [AW-1:0] aluSlot;

  logic          ldReady, aluReady;
  logic          ldPush, aluPush, pop;
  logic          empty;
  logic          doneSig;

  logic [7:0]    ldByte;
  logic [15:0]   ldHalf;
  logic [31:0]   ldValue;

  logic [AW-1:0] entryOffs [DEPTH];
  logic          entryLive [DEPTH];
  logic [31:0]   entryMask [DEPTH];
  logic [31:0]   busyMask;

  // Readies come only from the registered count; the ALU keeps one slot
  // in reserve so a same-cycle load always fits.
  assign ldReady  = (countReg <= CW'(DEPTH - 1));
  assign aluReady = (countReg <= CW'(DEPTH - 2));

  // rd=0 results complete the handshake but are never stored
  assign ldPush  = wb.iLD_VALID  && ldReady  && (wb.iLD_RD  != 5'd0);
  assign aluPush = wb.iALU_VALID && aluReady && (wb.iALU_RD != 5'd0);

  assign empty   = (countReg == '0);
  assign doneSig = !empty && !wb.iSTALL;
  assign pop     = doneSig;

  // The load is enqueued ahead of the ALU result on simultaneous accepts
  assign aluSlot = ldPush ? (wrPtrReg + AW'(1)) : wrPtrReg;

  // Load extraction: select byte/halfword by address and extend per funct3
  always_comb begin
    ldByte  = wb.iLD_DATA[8*wb.iLD_ADDR_LO +: 8];
    ldHalf  = wb.iLD_ADDR_LO[1] ? wb.iLD_DATA[31:16] : wb.iLD_DATA[15:0];
    ldValue = wb.iLD_DATA;
    case (wb.iLD_FUNCT3)
      3'b000:  ldValue = {{24{ldByte[7]}}, ldByte};
      3'b001:  ldValue = {{16{ldHalf[15]}}, ldHalf};
      3'b100:  ldValue = {24'd0, ldByte};
      3'b101:  ldValue = {16'd0, ldHalf};
      default: ldValue = wb.iLD_DATA;
    endcase
  end

  // Next pointer/count: occupancy moves by pushes minus pop
  always_comb begin
    wrPtrNext = wrPtrReg + AW'(ldPush) + AW'(aluPush);
    rdPtrNext = rdPtrReg + AW'(pop);
    countNext = countReg + CW'(ldPush) + CW'(aluPush) - CW'(pop);
  end

  // Entry writes; stale contents are harmless since count gates validity
  always_ff @(posedge iCLK) begin
    if (ldPush) begin
      rdMem[wrPtrReg]   <= wb.iLD_RD;
      dataMem[wrPtrReg] <= ldValue;
    end
    if (aluPush) begin
      rdMem[aluSlot]    <= wb.iALU_RD;
      dataMem[aluSlot]  <= wb.iALU_OUT;
    end
  end

  // Pointer and occupancy registers; reset empties the queue
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      rdPtrReg <= '0;
      wrPtrReg <= '0;
      countReg <= '0;
    end else begin
      rdPtrReg <= rdPtrNext;
      wrPtrReg <= wrPtrNext;
      countReg <= countNext;
    end
  end

  // Per-slot liveness: a slot is live when its distance from the head
  // is below the occupancy.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gSlot
      assign entryOffs[gi] = AW'(gi) - rdPtrReg;
      assign entryLive[gi] = ({1'b0, entryOffs[gi]} < countReg);
      assign entryMask[gi] = entryLive[gi] ? (32'd1 << rdMem[gi]) : 32'd0;
    end
  endgenerate

  // Pending-write mask: OR of one-hot destinations of all live slots
  always_comb begin
    busyMask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      busyMask = busyMask | entryMask[i];
    end
    busyMask[0] = 1'b0;
  end

  assign wb.oLD_READY  = ldReady;
  assign wb.oALU_READY = aluReady;
  assign wb.oDONE      = doneSig;
  assign wb.oRD        = empty ? 5'd0  : rdMem[rdPtrReg];
  assign wb.oWB_DATA   = empty ? 32'd0 : dataMem[rdPtrReg];
  assign wb.oBUSY_MASK = busyMask;
  assign wb.oCOUNT     = countReg;
endmodule
